// File: rtl/instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module  : instr_fetch_unit                                               |
// | Brief   : PC owner and instruction fetch front end. It issues req/ack    |
// |           reads to instruction memory and hands each word to decode      |
// |           over valid/ready. Redirects are applied through one port.      |
// | Option  : IFU_JUMP_PREDECODE_EN - follow J-type jumps locally.           |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [31:0] r_pc;
  logic        r_flush;
  logic [31:0] r_flush_target;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_seq_pc;
  logic [31:0] w_redirect_target;
  logic        w_unused_target_lsbs;

  assign w_pc_plus4           = r_pc + 32'd4;
  assign w_redirect_target    = {redirect_target[31:2], 2'b00};
  assign w_unused_target_lsbs = ^redirect_target[1:0];

`ifdef IFU_JUMP_PREDECODE_EN
  logic w_is_jump;
  assign w_is_jump = (imem_rdata[31:26] == 6'b000010);
  assign w_seq_pc  = w_is_jump ? {w_pc_plus4[31:28], imem_rdata[25:0], 2'b00}
                               : w_pc_plus4;
`else
  assign w_seq_pc  = w_pc_plus4;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          w_state_next = (redirect || r_flush) ? S_FETCH : S_HOLD;
        end
      end
      S_HOLD:  begin
        if (redirect || instr_ready) begin
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (r_state == S_FETCH);
    instr_valid = (r_state == S_HOLD);
  end

  // A redirect seen while a read is outstanding cannot abort it; the word
  // is flushed when its ack finally arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc           <= c_reset_pc;
      r_flush        <= 1'b0;
      r_flush_target <= 32'd0;
      r_instr        <= 32'd0;
      r_instr_pc     <= 32'd0;
      r_fetch_count  <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              r_pc    <= w_redirect_target;
              r_flush <= 1'b0;
            end else if (r_flush) begin
              r_pc    <= r_flush_target;
              r_flush <= 1'b0;
            end else begin
              r_instr    <= imem_rdata;
              r_instr_pc <= r_pc;
              r_pc       <= w_seq_pc;
            end
          end else if (redirect) begin
            r_flush        <= 1'b1;
            r_flush_target <= w_redirect_target;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc <= w_redirect_target;
          end else if (instr_ready) begin
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_unit                                            |
// | Brief   : Scoreboard bench for instr_fetch_unit with a latency-          |
// |           programmable instruction memory model.                         |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int lat    = 0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_pc_q   [$];
  logic [31:0] exp_ins_q  [$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: lw opcode with address-derived payload, one J-type word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0800_0010;
    return {6'b100011, a[27:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Memory model: ack after 'lat' wait cycles of a held request.
  initial begin
    int cnt;
    cnt = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          cnt        = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          cnt++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        cnt        = 0;
      end
    end
  end

  // Monitor: every completed memory read and every delivered instruction
  // is compared against the next scoreboard entry.
  initial begin
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr %h with empty queue", imem_addr);
        end else begin
          e_addr = exp_addr_q.pop_front();
          check("req_addr", imem_addr, e_addr);
        end
      end
      if (rst_n && instr_valid && instr_ready && !redirect) begin
        if (exp_pc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr: pc %h with empty queue", instr_pc);
        end else begin
          e_pc  = exp_pc_q.pop_front();
          e_ins = exp_ins_q.pop_front();
          check("deliver_pc", instr_pc, e_pc);
          check("deliver_instr", instr, e_ins);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] jmp_next;
    bit          seen;
`ifdef IFU_JUMP_PREDECODE_EN
    jmp_next = 32'h0000_0040;
`else
    jmp_next = 32'h0000_1004;
`endif
    rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
    repeat (3) step();

    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_count", fetch_count, 32'd0);

    // Zero-wait streaming of 0x0, 0x4, 0x8 with decode always ready.
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      exp_pc_q.push_back(32'(i * 4));
      exp_ins_q.push_back(mem_word(32'(i * 4)));
    end
    exp_addr_q.push_back(32'h0000_000C);
    rst_n = 1'b1; instr_ready = 1'b1;
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (fetch_count == 32'd3) begin
        seen = 1'b1;
        instr_ready = 1'b0;
      end
    end
    check("count_after_3", fetch_count, 32'd3);

    // Back-pressure: held word must stay put for five cycles.
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = instr_valid;
    end
    check("hold_reached", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_instr", instr, mem_word(32'h0000_000C));
      check("hold_pc", instr_pc, 32'h0000_000C);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_count", fetch_count, 32'd3);
      if (i < 4) step();
    end

    // Redirect and ready together in HOLD: redirect wins.
    redirect = 1'b1; redirect_target = 32'h0000_0103; instr_ready = 1'b1;
    exp_addr_q.push_back(32'h0000_0100);
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    check("hold_redir_addr", imem_addr, 32'h0000_0100);
    check("hold_redir_count", fetch_count, 32'd3);
    check("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    step();
    exp_pc_q.push_back(32'h0000_0100);
    exp_ins_q.push_back(mem_word(32'h0000_0100));
    instr_ready = 1'b1; lat = 3;

    // Three wait cycles, redirect in the second: returned word is flushed.
    step();
    instr_ready = 1'b0;
    exp_addr_q.push_back(32'h0000_0104);
    check("slow_req", {31'd0, imem_req}, 32'd1);
    check("slow_addr", imem_addr, 32'h0000_0104);
    step();
    redirect = 1'b1; redirect_target = 32'h0000_0040;
    step();
    redirect = 1'b0;
    check("flush_addr_stable", imem_addr, 32'h0000_0104);
    check("flush_valid0", {31'd0, instr_valid}, 32'd0);
    step();
    check("flush_ack_valid0", {31'd0, instr_valid}, 32'd0);
    exp_addr_q.push_back(32'h0000_0040);
    lat = 0;
    step();
    check("flush_new_addr", imem_addr, 32'h0000_0040);
    check("flush_valid_after", {31'd0, instr_valid}, 32'd0);
    step();
    check("t40_pc", instr_pc, 32'h0000_0040);
    check("t40_instr", instr, mem_word(32'h0000_0040));
    check("t40_count", fetch_count, 32'd4);

    // PC wrap from 0xFFFF_FFFC to 0, then reset in the middle of a wait.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    step();
    redirect = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_ins_q.push_back(mem_word(32'hFFFF_FFFC));
    exp_addr_q.push_back(32'h0000_0000);
    exp_pc_q.push_back(32'h0000_0000);
    exp_ins_q.push_back(mem_word(32'h0000_0000));
    instr_ready = 1'b1;
    step();
    step();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    lat = 5;
    step();
    step();
    check("wait_addr", imem_addr, 32'h0000_0004);
    check("wait_req", {31'd0, imem_req}, 32'd1);
    check("wait_count", fetch_count, 32'd6);
    rst_n = 1'b0; instr_ready = 1'b0;
    step();
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_count", fetch_count, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_instr_pc", instr_pc, 32'd0);
    lat = 0; rst_n = 1'b1;

    // Redirect on an acked cycle discards the word; then a J-type word.
    step();
    check("re_req", {31'd0, imem_req}, 32'd1);
    exp_addr_q.push_back(32'h0000_0000);
    redirect = 1'b1; redirect_target = 32'h0000_1000;
    step();
    redirect = 1'b0;
    check("jmp_addr", imem_addr, 32'h0000_1000);
    check("ack_redir_valid0", {31'd0, instr_valid}, 32'd0);
    exp_addr_q.push_back(32'h0000_1000);
    exp_pc_q.push_back(32'h0000_1000);
    exp_ins_q.push_back(32'h0800_0010);
    instr_ready = 1'b1;
    step();
    check("jmp_instr", instr, 32'h0800_0010);
    step();
    check("jmp_next_addr", imem_addr, jmp_next);
    exp_addr_q.push_back(jmp_next);
    instr_ready = 1'b0;
    step();
    check("jmp_next_pc", instr_pc, jmp_next);
    check("jmp_count", fetch_count, 32'd1);
    repeat (3) step();

    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("instr_queue_empty", 32'(exp_pc_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
